// File: rtl/port_arbiter.sv
// Two-port memory arbiter: fetch port A (read-only) and data port B (read/write)
// share one memory-side request channel. Ports alternate grants under contention.
// The granted request is latched on entry to service, so port inputs may change or
// drop while memory is working without affecting the memory-side request.

module port_arbiter (
    input  logic        clk,
    input  logic        reset,

    // Fetch port
    input  logic        read_a,
    input  logic [15:0] address_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,

    // Data port
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,

    // Memory side
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_wmask,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StServeA,
        StServeB,
        StDoneA,
        StDoneB
    } state_e;

    state_e      state_q;
    logic        last_grant_q;  // 1: port B was granted last
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        write_q;       // latched op of the granted request
    logic        mem_read_q;
    logic        mem_write_q;
    logic [1:0]  mem_wmask_q;
    logic        resp_a_q;
    logic        resp_b_q;
    logic [15:0] rdata_a_q;
    logic [15:0] rdata_b_q;

    logic pend_a;
    logic pend_b;
    logic grant_a;

    // Arbitration: A wins a tie only when B had the previous grant.
    always_comb begin
        pend_a  = read_a;
        pend_b  = read_b | write_b;
        grant_a = pend_a & (~pend_b | last_grant_q);
    end

    // Single FSM with registered outputs; memory-side signals come only from latched state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            write_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wmask_q  <= 2'b00;
            resp_a_q     <= 1'b0;
            resp_b_q     <= 1'b0;
            rdata_a_q    <= 16'h0000;
            rdata_b_q    <= 16'h0000;
        end else begin
            resp_a_q <= 1'b0;
            resp_b_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_a) begin
                        state_q      <= StServeA;
                        last_grant_q <= 1'b0;
                        addr_q       <= address_a;
                        wdata_q      <= 16'h0000;
                        write_q      <= 1'b0;
                        mem_read_q   <= 1'b1;
                        mem_write_q  <= 1'b0;
                        mem_wmask_q  <= 2'b00;
                    end else if (pend_b) begin
                        // A simultaneous read and write request is served as a write.
                        state_q      <= StServeB;
                        last_grant_q <= 1'b1;
                        addr_q       <= address_b;
                        wdata_q      <= wdata_b;
                        write_q      <= write_b;
                        mem_read_q   <= ~write_b;
                        mem_write_q  <= write_b;
                        mem_wmask_q  <= write_b ? wmask_b : 2'b00;
                    end
                end
                StServeA: begin
                    if (mem_resp) begin
                        state_q     <= StDoneA;
                        rdata_a_q   <= mem_rdata;
                        resp_a_q    <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_wmask_q <= 2'b00;
                    end
                end
                StServeB: begin
                    if (mem_resp) begin
                        state_q     <= StDoneB;
                        if (!write_q) begin
                            rdata_b_q <= mem_rdata;
                        end
                        resp_b_q    <= 1'b1;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_wmask_q <= 2'b00;
                    end
                end
                StDoneA, StDoneB: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign resp_a      = resp_a_q;
    assign resp_b      = resp_b_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wmask   = mem_wmask_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed scenarios plus a randomized transaction loop checked
// against a transaction-level model (round-robin grant bit, byte-masked memory array).

module tb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        read_a = 1'b0;
    logic [15:0] address_a = 16'h0;
    logic        resp_a;
    logic [15:0] rdata_a;
    logic        read_b = 1'b0;
    logic        write_b = 1'b0;
    logic [1:0]  wmask_b = 2'b0;
    logic [15:0] address_b = 16'h0;
    logic [15:0] wdata_b = 16'h0;
    logic        resp_b;
    logic [15:0] rdata_b;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          model_last_b;
    logic [15:0] exp_rdata_a;
    logic [15:0] exp_rdata_b;
    logic [15:0] mem_model [logic [15:0]];

    always #5 clk = ~clk;

    port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .read_a     (read_a),
        .address_a  (address_a),
        .resp_a     (resp_a),
        .rdata_a    (rdata_a),
        .read_b     (read_b),
        .write_b    (write_b),
        .wmask_b    (wmask_b),
        .address_b  (address_b),
        .wdata_b    (wdata_b),
        .resp_b     (resp_b),
        .rdata_b    (rdata_b),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wmask  (mem_wmask),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
    );

    function automatic logic [15:0] mem_val(input logic [15:0] addr);
        if (mem_model.exists(addr)) return mem_model[addr];
        return addr ^ 16'h5A5A;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        read_a   = 1'b0;
        read_b   = 1'b0;
        write_b  = 1'b0;
        mem_resp = 1'b0;
    endtask

    task automatic model_reset();
        model_last_b = 1'b1;
        exp_rdata_a  = 16'h0000;
        exp_rdata_b  = 16'h0000;
    endtask

    task automatic test_reset();
        drop_all();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({mem_read, mem_write, mem_wmask, resp_a, resp_b} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mem_read, mem_write, mem_wmask, resp_a, resp_b});
        end
        vectors++;
        if ({mem_address, mem_wdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mem_bus: got %h/%h want 0000/0000", mem_address, mem_wdata);
        end
        vectors++;
        if ({rdata_a, rdata_b} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h want 0000/0000", rdata_a, rdata_b);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_a_only();
        read_a    = 1'b1;
        address_a = 16'h0040;
        tick();  // SERVE_A
        vectors++;
        if ({mem_read, mem_write, mem_wmask} !== 4'b1000 || mem_address !== 16'h0040) begin
            miscompares++;
            $display("FAIL a_only_issue: got rd=%b wr=%b m=%b addr=%h want 1 0 00 0040",
                     mem_read, mem_write, mem_wmask, mem_address);
        end
        tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_address !== 16'h0040 || resp_a !== 1'b0) begin
            miscompares++;
            $display("FAIL a_only_hold: got rd=%b addr=%h resp_a=%b want 1 0040 0",
                     mem_read, mem_address, resp_a);
        end
        mem_resp  = 1'b1;
        mem_rdata = 16'h1234;
        tick();  // DONE_A
        mem_resp  = 1'b0;
        read_a    = 1'b0;
        vectors++;
        if (resp_a !== 1'b1 || resp_b !== 1'b0 || rdata_a !== 16'h1234 || mem_read !== 1'b0) begin
            miscompares++;
            $display("FAIL a_only_resp: got resp_a=%b resp_b=%b rdata_a=%h rd=%b want 1 0 1234 0",
                     resp_a, resp_b, rdata_a, mem_read);
        end
        tick();  // IDLE
        vectors++;
        if (resp_a !== 1'b0 || rdata_a !== 16'h1234) begin
            miscompares++;
            $display("FAIL a_only_single_pulse: got resp_a=%b rdata_a=%h want 0 1234",
                     resp_a, rdata_a);
        end
        model_last_b = 1'b0;
        exp_rdata_a  = 16'h1234;
    endtask

    task automatic test_b_write();
        write_b   = 1'b1;
        address_b = 16'h0100;
        wdata_b   = 16'hBEEF;
        wmask_b   = 2'b01;
        tick();  // SERVE_B
        vectors++;
        if ({mem_read, mem_write, mem_wmask} !== 4'b0101 || mem_wdata !== 16'hBEEF ||
            mem_address !== 16'h0100) begin
            miscompares++;
            $display("FAIL b_write_issue: got rd=%b wr=%b m=%b wd=%h addr=%h want 0 1 01 beef 0100",
                     mem_read, mem_write, mem_wmask, mem_wdata, mem_address);
        end
        mem_resp  = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();  // DONE_B
        mem_resp  = 1'b0;
        write_b   = 1'b0;
        vectors++;
        if (resp_b !== 1'b1 || resp_a !== 1'b0 || rdata_b !== exp_rdata_b || mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL b_write_resp: got resp_b=%b resp_a=%b rdata_b=%h wr=%b want 1 0 %h 0",
                     resp_b, resp_a, rdata_b, mem_write, exp_rdata_b);
        end
        tick();
        vectors++;
        if (resp_b !== 1'b0) begin
            miscompares++;
            $display("FAIL b_write_single_pulse: got resp_b=%b want 0", resp_b);
        end
        model_last_b = 1'b1;
        mem_model[16'h0100] = {mem_val(16'h0100)[15:8], 8'hEF};
    endtask

    task automatic test_contention();
        bit exp_a;
        logic [15:0] want_addr;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        read_a    = 1'b1;
        address_a = 16'h0010;
        read_b    = 1'b1;
        address_b = 16'h0020;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2) == 0;
            want_addr = exp_a ? 16'h0010 : 16'h0020;
            tick();  // SERVE
            vectors++;
            if (mem_read !== 1'b1 || mem_address !== want_addr) begin
                miscompares++;
                $display("FAIL contention_grant%0d: got rd=%b addr=%h want 1 %h",
                         i, mem_read, mem_address, want_addr);
            end
            mem_resp  = 1'b1;
            mem_rdata = 16'hC000 + 16'(i);
            tick();  // DONE
            mem_resp = 1'b0;
            vectors++;
            if (resp_a !== exp_a || resp_b !== !exp_a) begin
                miscompares++;
                $display("FAIL contention_resp%0d: got a=%b b=%b want a=%b b=%b",
                         i, resp_a, resp_b, exp_a, !exp_a);
            end
            tick();  // IDLE
        end
        drop_all();
        model_last_b = 1'b1;
        exp_rdata_a  = 16'hC002;
        exp_rdata_b  = 16'hC003;
        tick();
    endtask

    task automatic test_midflight();
        read_b    = 1'b1;
        address_b = 16'h0100;
        tick();  // SERVE_B (A idle, so B regardless of last grant)
        address_b = 16'h0200;
        write_b   = 1'b1;
        wdata_b   = 16'h7777;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (mem_address !== 16'h0100 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
                miscompares++;
                $display("FAIL midflight_hold%0d: got addr=%h rd=%b wr=%b want 0100 1 0",
                         i, mem_address, mem_read, mem_write);
            end
            if (i == 1) begin
                mem_resp  = 1'b1;
                mem_rdata = mem_val(16'h0100);
            end
            tick();
        end
        // DONE_B
        mem_resp = 1'b0;
        read_b   = 1'b0;
        write_b  = 1'b0;
        exp_rdata_b  = mem_val(16'h0100);
        model_last_b = 1'b1;
        vectors++;
        if (resp_b !== 1'b1 || rdata_b !== exp_rdata_b || mem_address !== 16'h0100) begin
            miscompares++;
            $display("FAIL midflight_done: got resp_b=%b rdata_b=%h addr=%h want 1 %h 0100",
                     resp_b, rdata_b, mem_address, exp_rdata_b);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        read_a    = 1'b1;
        address_a = 16'h0333;
        tick();  // SERVE_A
        vectors++;
        if (mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_issue: got rd=%b want 1", mem_read);
        end
        reset  = 1'b1;
        read_a = 1'b0;
        tick();
        reset     = 1'b0;
        model_reset();
        mem_resp  = 1'b1;
        mem_rdata = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({resp_a, resp_b, mem_read, mem_write} !== 4'b0 || rdata_a !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_mid_quiet%0d: got ra=%b rb=%b rd=%b wr=%b rdata_a=%h want 0 0 0 0 0000",
                         i, resp_a, resp_b, mem_read, mem_write, rdata_a);
            end
            mem_resp = 1'b0;
        end
    endtask

    task automatic test_stray();
        drop_all();
        for (int i = 0; i < 3; i++) begin
            mem_resp  = 1'b1;
            mem_rdata = 16'($urandom);
            tick();
            vectors++;
            if ({resp_a, resp_b, mem_read, mem_write} !== 4'b0 ||
                rdata_a !== exp_rdata_a || rdata_b !== exp_rdata_b) begin
                miscompares++;
                $display("FAIL stray_resp%0d: got ra=%b rb=%b rd=%b wr=%b rdata=%h/%h want 0 0 0 0 %h/%h",
                         i, resp_a, resp_b, mem_read, mem_write, rdata_a, rdata_b,
                         exp_rdata_a, exp_rdata_b);
            end
        end
        mem_resp = 1'b0;
        tick();
    endtask

    task automatic test_random();
        bit          pend_a, pend_b, b_wr, grant_a, is_write;
        logic [15:0] a_addr, b_addr, b_wdata, exp_addr, exp_wd, value, old;
        logic [1:0]  b_mask, exp_mask;
        int          lat, op;
        pend_a = 1'b0;
        pend_b = 1'b0;
        b_wr   = 1'b0;
        b_addr = 16'h0;
        b_wdata = 16'h0;
        b_mask = 2'b0;
        a_addr = 16'h0;
        for (int n = 0; n < 300; n++) begin
            // IDLE cycle: possibly raise new requests
            if (!pend_a && $urandom_range(0, 2) != 0) begin
                pend_a    = 1'b1;
                a_addr    = 16'($urandom_range(0, 15));
                read_a    = 1'b1;
                address_a = a_addr;
            end
            if (!pend_b && $urandom_range(0, 2) != 0) begin
                pend_b    = 1'b1;
                op        = $urandom_range(0, 2);  // 0 read, 1 write, 2 both
                b_wr      = op != 0;
                b_addr    = 16'($urandom_range(0, 15));
                b_wdata   = 16'($urandom);
                b_mask    = 2'($urandom);
                read_b    = op != 1;
                write_b   = b_wr;
                address_b = b_addr;
                wdata_b   = b_wdata;
                wmask_b   = b_mask;
            end
            mem_resp  = 1'($urandom);
            mem_rdata = 16'($urandom);
            if (!pend_a && !pend_b) begin
                tick();
                vectors++;
                if ({resp_a, resp_b, mem_read, mem_write} !== 4'b0) begin
                    miscompares++;
                    $display("FAIL rand_idle%0d: got ra=%b rb=%b rd=%b wr=%b want all 0",
                             n, resp_a, resp_b, mem_read, mem_write);
                end
                continue;
            end
            grant_a      = pend_a && (!pend_b || model_last_b);
            model_last_b = !grant_a;
            is_write     = !grant_a && b_wr;
            exp_addr     = grant_a ? a_addr : b_addr;
            exp_mask     = is_write ? b_mask : 2'b00;
            exp_wd       = b_wdata;
            lat          = $urandom_range(0, 3);
            tick();  // first SERVE cycle
            mem_resp = 1'b0;
            for (int c = 0; c <= lat; c++) begin
                vectors++;
                if (mem_read !== !is_write || mem_write !== is_write || mem_address !== exp_addr ||
                    mem_wmask !== exp_mask || (is_write && mem_wdata !== exp_wd) ||
                    resp_a !== 1'b0 || resp_b !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_serve%0d.%0d: got rd=%b wr=%b addr=%h m=%b wd=%h ra=%b rb=%b want rd=%b wr=%b addr=%h m=%b wd=%h",
                             n, c, mem_read, mem_write, mem_address, mem_wmask, mem_wdata,
                             resp_a, resp_b, !is_write, is_write, exp_addr, exp_mask, exp_wd);
                end
                // Disturb the served port only; the waiting port must stay stable.
                if (grant_a) begin
                    address_a = 16'($urandom);
                    read_a    = 1'($urandom);
                end else begin
                    address_b = 16'($urandom);
                    wdata_b   = 16'($urandom);
                    wmask_b   = 2'($urandom);
                    read_b    = 1'($urandom);
                    write_b   = 1'($urandom);
                end
                if (c == lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = is_write ? 16'($urandom) : mem_val(exp_addr);
                end
                tick();
            end
            // DONE cycle
            value = mem_rdata;
            if (grant_a) begin
                exp_rdata_a = value;
            end else if (!is_write) begin
                exp_rdata_b = value;
            end else begin
                old = mem_val(exp_addr);
                mem_model[exp_addr] = {b_mask[1] ? b_wdata[15:8] : old[15:8],
                                       b_mask[0] ? b_wdata[7:0]  : old[7:0]};
            end
            vectors++;
            if (resp_a !== grant_a || resp_b !== !grant_a || mem_read !== 1'b0 ||
                mem_write !== 1'b0 || rdata_a !== exp_rdata_a || rdata_b !== exp_rdata_b) begin
                miscompares++;
                $display("FAIL rand_done%0d: got ra=%b rb=%b rd=%b wr=%b rdata=%h/%h want ra=%b rb=%b rd=0 wr=0 rdata=%h/%h",
                         n, resp_a, resp_b, mem_read, mem_write, rdata_a, rdata_b,
                         grant_a, !grant_a, exp_rdata_a, exp_rdata_b);
            end
            if (grant_a) begin
                pend_a = 1'b0;
                read_a = 1'b0;
            end else begin
                pend_b  = 1'b0;
                read_b  = 1'b0;
                write_b = 1'b0;
            end
            mem_resp  = 1'($urandom);  // ignored in DONE
            mem_rdata = 16'($urandom);
            tick();  // back to IDLE
            vectors++;
            if (resp_a !== 1'b0 || resp_b !== 1'b0 || rdata_a !== exp_rdata_a ||
                rdata_b !== exp_rdata_b) begin
                miscompares++;
                $display("FAIL rand_after%0d: got ra=%b rb=%b rdata=%h/%h want 0 0 %h/%h",
                         n, resp_a, resp_b, rdata_a, rdata_b, exp_rdata_a, exp_rdata_b);
            end
            mem_resp = 1'b0;
        end
        drop_all();
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_a_only();
        test_b_write();
        test_stray();
        test_contention();
        test_midflight();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameters: none; all datapaths are fixed at 16 bits, and masks are 2 bits.
REQ-002 The clock and reset SHALL be one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 read_a  in  1  fetch-port read request, held until resp_a.
REQ-006 address_a  in  16  fetch-port word address.
REQ-007 resp_a  out  1  one-cycle fetch completion pulse.
REQ-008 rdata_a  out  16  fetch read data, valid while resp_a=1.
REQ-009 read_b, write_b  in  1 each  data-port read and write requests, held until resp_b.
REQ-010 wmask_b  in  2  data-port byte-write mask.
REQ-011 address_b, wdata_b  in  16 each  data-port address and write data.
REQ-012 resp_b  out  1  one-cycle data completion pulse.
REQ-013 rdata_b  out  16  data-port read data, valid while resp_b=1.
REQ-014 mem_read, mem_write  out  1 each  memory-side requests.
REQ-015 mem_wmask  out  2  memory-side byte mask.
REQ-016 mem_address, mem_wdata  out  16 each  memory-side address and write data.
REQ-017 mem_resp  in  1  memory-side completion.
REQ-018 mem_rdata  in  16  memory-side read data, valid with mem_resp.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, SERVE_A, SERVE_B, DONE_A, DONE_B.
REQ-020 IDLE: a request SHALL be pending on A when read_a=1, and on B when read_b|write_b=1.
REQ-021 IDLE with one port pending -> the FSM SHALL move to that port's SERVE state.
REQ-022 IDLE with both ports pending -> SERVE_A if last_grant=B, else SERVE_B.
REQ-023 last_grant SHALL be a 1-bit register updated on each SERVE entry.
REQ-024 On the IDLE->SERVE edge, the granted port's address, wdata, wmask and op SHALL be latched into registers.
REQ-025 mem_* outputs SHALL be driven only from the registers in REQ-024, never from the live port inputs.
REQ-026 SERVE_A: mem_read=1, mem_write=0, mem_wmask=2'b00.
REQ-027 SERVE_B read: mem_read=1, mem_write=0, mem_wmask=2'b00.
REQ-028 SERVE_B write: mem_write=1, mem_read=0, mem_wmask=latched wmask_b.
REQ-029 If read_b and write_b are both 1 at grant, the access SHALL be a write.
REQ-030 SERVE_x SHALL hold its mem outputs stable until mem_resp=1.
REQ-031 SERVE_x with mem_resp=1 -> DONE_x; mem_rdata SHALL be captured into rdata_x.
REQ-032 DONE_x: resp_x=1 for exactly one cycle, all mem_* requests=0, next state IDLE.
REQ-033 Latency: a request sampled in IDLE at cycle t SHALL drive mem outputs at t+1.
REQ-034 Latency: mem_resp at cycle k SHALL give resp_x at k+1 and IDLE at k+2.
REQ-035 Minimum round trip SHALL be 3 cycles (IDLE, SERVE with immediate mem_resp, DONE).
REQ-036 rdata_a and rdata_b SHALL hold their last captured value between responses.
REQ-037 rdata_b SHALL be unchanged by a write transaction.
REQ-038 mem_resp in IDLE or DONE_x SHALL be ignored.
REQ-039 A requester dropping its request mid-SERVE SHALL NOT abort the transaction; it completes and resp still pulses.
REQ-040 Port inputs changing during SERVE SHALL NOT alter mem outputs.
REQ-041 resp_a and resp_b SHALL never be 1 in the same cycle.
REQ-042 mem_read and mem_write SHALL never be 1 in the same cycle.

Reset
REQ-043 Reset SHALL force state=IDLE and last_grant=B.
REQ-044 Reset SHALL force all mem_* outputs, resp_a and resp_b to 0.
REQ-045 Reset SHALL force rdata_a=rdata_b=16'h0000 and the latched registers to 0.
REQ-046 Reset mid-transaction SHALL discard the transaction with no resp pulse; a following mem_resp is ignored.
REQ-047 After reset, both ports pending SHALL grant A first, since last_grant=B.

Verification
REQ-048 A-only: read_a=1, address_a=16'h0040; memory replies after 2 cycles with 16'h1234 -> mem_address=16'h0040 and mem_read=1 from t+1; resp_a pulses once; rdata_a=16'h1234.
REQ-049 B write: write_b=1, address_b=16'h0100, wdata_b=16'hBEEF, wmask_b=2'b01 -> mem_write=1, mem_wmask=2'b01, mem_wdata=16'hBEEF; resp_b once; rdata_b unchanged.
REQ-050 Contention after reset: read_a and read_b both held continuously -> grants alternate A,B,A,B over 4 transactions; resp pulses never overlap.
REQ-051 Mid-flight change: address_b changes 16'h0100->16'h0200 during SERVE_B -> mem_address stays 16'h0100 until DONE_B.
REQ-052 Reset in SERVE_A, then mem_resp=1 the next cycle -> no resp_a; state IDLE; outputs 0.
REQ-053 Stray mem_resp=1 in IDLE with no requests -> no resp pulse; rdata registers unchanged.
